// File: rtl/trig_pueo_command_rx.sv
// trig_pueo_command_rx: receives TURF command words, checks parity/alignment, decodes triggers, run commands and messages
module trig_pueo_command_rx #(
    parameter SYSCLKTYPE = "NONE",
    parameter int CHECK_PARITY = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     sysclk_i,
    input  logic                     sysclk_rstn_i,
    input  logic                     sysclk_phase_i,
    input  logic [31:0]              command_i,
    output logic                     trig_valid_o,
    output logic [14:0]              trig_time_o,
    output logic [1:0]               runcmd_o,
    output logic                     runcmd_valid_o,
    output logic                     msg_valid_o,
    output logic [31:0]              msg_data_o,
    output logic [ERR_CNT_WIDTH-1:0] parity_err_cnt_o,
    output logic [ERR_CNT_WIDTH-1:0] proto_err_cnt_o,
    output logic                     align_err_o
);
    typedef enum logic [1:0] {IDLE, B1, B2, B3} msg_state_t;
    localparam logic [1:0] CTL_START = 2'b01, CTL_CONT = 2'b10, CTL_END = 2'b11;

    logic                     cap_vld_q, cap_vld_d;
    logic [31:0]              cap_word_q, cap_word_d;
    logic                     dec_vld_q, dec_vld_d;
    logic                     dec_good_q, dec_good_d;
    logic [31:0]              dec_word_q, dec_word_d;
    logic [2:0]               align_cnt_q, align_cnt_d;
    logic                     armed_q, armed_d;
    logic                     align_err_q, align_err_d;
    logic                     trig_valid_q, trig_valid_d;
    logic [14:0]              trig_time_q, trig_time_d;
    logic                     runcmd_valid_q, runcmd_valid_d;
    logic [1:0]               runcmd_q, runcmd_d;
    logic [ERR_CNT_WIDTH-1:0] parity_cnt_q, parity_cnt_d;
    msg_state_t               msg_state_q;
    logic [23:0]              msg_buf_q;
    logic                     msg_valid_q;
    logic [31:0]              msg_data_q;
    logic [ERR_CNT_WIDTH-1:0] proto_cnt_q;
    logic                     dec_ok, proto_hit;
    logic [1:0]               msg_ctl;
    logic [7:0]               msg_byte;
    logic                     unused_ok;

    assign dec_ok   = dec_vld_q && dec_good_q;
    assign msg_ctl  = dec_word_q[7:6];
    assign msg_byte = dec_word_q[15:8];
    assign unused_ok = ^{dec_word_q[3:0], SYSCLKTYPE != "NONE"};

    // Capture, parity stage, field decode, error counting and alignment tracking
    always_comb begin
        cap_vld_d      = sysclk_phase_i;
        cap_word_d     = sysclk_phase_i ? command_i : cap_word_q;
        dec_vld_d      = cap_vld_q;
        dec_word_d     = cap_word_q;
        dec_good_d     = (CHECK_PARITY == 0) || !(^cap_word_q);
        trig_valid_d   = dec_ok && dec_word_q[31];
        trig_time_d    = trig_valid_d ? dec_word_q[30:16] : trig_time_q;
        runcmd_valid_d = dec_ok && |dec_word_q[5:4];
        runcmd_d       = runcmd_valid_d ? dec_word_q[5:4] : runcmd_q;
        parity_cnt_d   = (dec_vld_q && !dec_good_q && !(&parity_cnt_q)) ? parity_cnt_q + ERR_CNT_WIDTH'(1) : parity_cnt_q;
        armed_d        = armed_q || sysclk_phase_i;
        align_cnt_d    = sysclk_phase_i ? 3'd0 : align_cnt_q + 3'd1;
        align_err_d    = align_err_q || (armed_q && (sysclk_phase_i ? align_cnt_q != 3'd7 : align_cnt_q == 3'd7));
        proto_hit      = dec_ok && ((msg_state_q == IDLE) ? (msg_ctl == CTL_CONT || msg_ctl == CTL_END) :
                                    (msg_state_q == B3)   ? (msg_ctl == CTL_START || msg_ctl == CTL_CONT) :
                                                            (msg_ctl == CTL_START || msg_ctl == CTL_END));
    end

    // Pipeline, decoded-output and alignment registers
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            cap_vld_q      <= 1'b0;
            cap_word_q     <= '0;
            dec_vld_q      <= 1'b0;
            dec_word_q     <= '0;
            dec_good_q     <= 1'b0;
            trig_valid_q   <= 1'b0;
            trig_time_q    <= '0;
            runcmd_valid_q <= 1'b0;
            runcmd_q       <= '0;
            parity_cnt_q   <= '0;
            armed_q        <= 1'b0;
            align_cnt_q    <= '0;
            align_err_q    <= 1'b0;
        end else begin
            cap_vld_q      <= cap_vld_d;
            cap_word_q     <= cap_word_d;
            dec_vld_q      <= dec_vld_d;
            dec_word_q     <= dec_word_d;
            dec_good_q     <= dec_good_d;
            trig_valid_q   <= trig_valid_d;
            trig_time_q    <= trig_time_d;
            runcmd_valid_q <= runcmd_valid_d;
            runcmd_q       <= runcmd_d;
            parity_cnt_q   <= parity_cnt_d;
            armed_q        <= armed_d;
            align_cnt_q    <= align_cnt_d;
            align_err_q    <= align_err_d;
        end
    end

    // Message reassembly FSM; state names count the bytes already held
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            msg_state_q <= IDLE;
            msg_buf_q   <= '0;
            msg_valid_q <= 1'b0;
            msg_data_q  <= '0;
            proto_cnt_q <= '0;
        end else begin
            msg_valid_q <= 1'b0;
            if (proto_hit && !(&proto_cnt_q))
                proto_cnt_q <= proto_cnt_q + ERR_CNT_WIDTH'(1);
            if (dec_ok) begin
                case (msg_ctl)
                    CTL_START: begin
                        msg_buf_q[7:0] <= msg_byte;
                        msg_state_q    <= B1;
                    end
                    CTL_CONT: begin
                        if (msg_state_q == B1) begin
                            msg_buf_q[15:8] <= msg_byte;
                            msg_state_q     <= B2;
                        end else if (msg_state_q == B2) begin
                            msg_buf_q[23:16] <= msg_byte;
                            msg_state_q      <= B3;
                        end else begin
                            msg_state_q <= IDLE;
                        end
                    end
                    CTL_END: begin
                        if (msg_state_q == B3) begin
                            msg_valid_q <= 1'b1;
                            msg_data_q  <= {msg_byte, msg_buf_q};
                        end
                        msg_state_q <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign trig_valid_o     = trig_valid_q;
    assign trig_time_o      = trig_time_q;
    assign runcmd_o         = runcmd_q;
    assign runcmd_valid_o   = runcmd_valid_q;
    assign msg_valid_o      = msg_valid_q;
    assign msg_data_o       = msg_data_q;
    assign parity_err_cnt_o = parity_cnt_q;
    assign proto_err_cnt_o  = proto_cnt_q;
    assign align_err_o      = align_err_q;
endmodule

// File: tb/tb_trig_pueo_command_rx.sv
// tb_trig_pueo_command_rx: scoreboard bench for the TURF command receiver (parity checked and unchecked instances)
module tb_trig_pueo_command_rx;
    localparam logic [1:0] C_IDLE = 2'b00, C_START = 2'b01, C_CONT = 2'b10, C_END = 2'b11;

    typedef struct {
        bit          trig;
        bit [14:0]   tt;
        bit          rv;
        bit [1:0]    rc;
        bit          mv;
        bit [31:0]   md;
        bit [1:0]    pe;
        bit [1:0]    pr;
        bit          al;
        bit          trig2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phase = 1'b0;
    logic [31:0] command = '0;
    logic        trig_valid, runcmd_valid, msg_valid, align_err;
    logic [14:0] trig_time;
    logic [1:0]  runcmd;
    logic [31:0] msg_data;
    logic [1:0]  perr, proto;
    logic        trig_valid2, runcmd_valid2, msg_valid2, align_err2;
    logic [14:0] trig_time2;
    logic [1:0]  runcmd2;
    logic [31:0] msg_data2;
    logic [1:0]  perr2, proto2;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [1:0] hist = '0;

    bit        armed_m, m_align;
    int        prev_gap, m_st;
    bit [14:0] m_tt;
    bit [1:0]  m_rc, m_pe, m_pr;
    bit [31:0] m_md;
    bit [7:0]  m_b[3];

    trig_pueo_command_rx #(.CHECK_PARITY(1), .ERR_CNT_WIDTH(2)) dut (
        .sysclk_i(clk), .sysclk_rstn_i(rst_n), .sysclk_phase_i(phase), .command_i(command),
        .trig_valid_o(trig_valid), .trig_time_o(trig_time), .runcmd_o(runcmd), .runcmd_valid_o(runcmd_valid),
        .msg_valid_o(msg_valid), .msg_data_o(msg_data), .parity_err_cnt_o(perr), .proto_err_cnt_o(proto),
        .align_err_o(align_err)
    );

    trig_pueo_command_rx #(.CHECK_PARITY(0), .ERR_CNT_WIDTH(2)) dut_np (
        .sysclk_i(clk), .sysclk_rstn_i(rst_n), .sysclk_phase_i(phase), .command_i(command),
        .trig_valid_o(trig_valid2), .trig_time_o(trig_time2), .runcmd_o(runcmd2), .runcmd_valid_o(runcmd_valid2),
        .msg_valid_o(msg_valid2), .msg_data_o(msg_data2), .parity_err_cnt_o(perr2), .proto_err_cnt_o(proto2),
        .align_err_o(align_err2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input bit t, input logic [14:0] tt, input logic [7:0] b,
                                       input logic [1:0] ctl, input logic [1:0] rc);
        logic [31:0] w;
        w = {t, tt, b, ctl, rc, 3'b101, 1'b0};
        w[0] = ^w[31:1];
        return w;
    endfunction

    // Scoreboard monitor: a word sampled at edge N is compared just after edge N+2
    always @(posedge clk) begin
        bit   chk;
        exp_t e;
        if (!rst_n) begin
            hist = '0;
        end else begin
            chk = hist[1];
            hist = {hist[0], phase};
            #1;
            if (chk) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: DUT result cycle with no expected entry");
                end else begin
                    e = q.pop_front();
                    checks++; if (trig_valid !== e.trig) begin errors++; $display("FAIL trig_valid got %0b exp %0b", trig_valid, e.trig); end
                    checks++; if (trig_time !== e.tt) begin errors++; $display("FAIL trig_time got %h exp %h", trig_time, e.tt); end
                    checks++; if (runcmd_valid !== e.rv) begin errors++; $display("FAIL runcmd_valid got %0b exp %0b", runcmd_valid, e.rv); end
                    checks++; if (runcmd !== e.rc) begin errors++; $display("FAIL runcmd got %0d exp %0d", runcmd, e.rc); end
                    checks++; if (msg_valid !== e.mv) begin errors++; $display("FAIL msg_valid got %0b exp %0b", msg_valid, e.mv); end
                    checks++; if (msg_data !== e.md) begin errors++; $display("FAIL msg_data got %h exp %h", msg_data, e.md); end
                    checks++; if (perr !== e.pe) begin errors++; $display("FAIL parity_cnt got %0d exp %0d", perr, e.pe); end
                    checks++; if (proto !== e.pr) begin errors++; $display("FAIL proto_cnt got %0d exp %0d", proto, e.pr); end
                    checks++; if (align_err !== e.al) begin errors++; $display("FAIL align_err got %0b exp %0b", align_err, e.al); end
                    checks++; if (trig_valid2 !== e.trig2) begin errors++; $display("FAIL nopar_trig_valid got %0b exp %0b", trig_valid2, e.trig2); end
                    checks++; if (perr2 !== 2'd0) begin errors++; $display("FAIL nopar_parity_cnt got %0d exp 0", perr2); end
                end
            end else begin
                checks++;
                if ({trig_valid, runcmd_valid, msg_valid, trig_valid2} !== 4'b0) begin
                    errors++;
                    $display("FAIL idle_strobes got %b exp 0000", {trig_valid, runcmd_valid, msg_valid, trig_valid2});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        phase = 1'b0;
        q.delete();
        armed_m = 0; m_align = 0; prev_gap = 8; m_st = 0;
        m_tt = '0; m_rc = '0; m_pe = '0; m_pr = '0; m_md = '0;
        m_b[0] = '0; m_b[1] = '0; m_b[2] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        exp_t e;
        bit err;
        logic [1:0] ctl;
        logic [7:0] b;
        ctl = w[7:6];
        b = w[15:8];
        if (armed_m && prev_gap != 8) m_align = 1;
        armed_m = 1;
        prev_gap = gap;
        e.trig = 0; e.rv = 0; e.mv = 0; e.trig2 = w[31];
        if (^w) begin
            m_pe = (m_pe == 2'd3) ? 2'd3 : m_pe + 2'd1;
        end else begin
            e.trig = w[31];
            if (e.trig) m_tt = w[30:16];
            e.rv = (w[5:4] != 2'd0);
            if (e.rv) m_rc = w[5:4];
            err = 0;
            case (m_st)
                0: if (ctl == C_START) begin m_b[0] = b; m_st = 1; end
                   else if (ctl != C_IDLE) err = 1;
                1, 2: if (ctl == C_CONT) begin m_b[m_st] = b; m_st++; end
                      else if (ctl == C_START) begin err = 1; m_b[0] = b; m_st = 1; end
                      else if (ctl == C_END) begin err = 1; m_st = 0; end
                default: if (ctl == C_END) begin m_md = {b, m_b[2], m_b[1], m_b[0]}; e.mv = 1; m_st = 0; end
                         else if (ctl == C_CONT) begin err = 1; m_st = 0; end
                         else if (ctl == C_START) begin err = 1; m_b[0] = b; m_st = 1; end
            endcase
            if (err) m_pr = (m_pr == 2'd3) ? 2'd3 : m_pr + 2'd1;
        end
        e.tt = m_tt; e.rc = m_rc; e.md = m_md; e.pe = m_pe; e.pr = m_pr; e.al = m_align;
        q.push_back(e);
        command = w;
        phase = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            phase = 1'b0;
            command = $urandom;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (trig_valid !== 1'b0 || runcmd_valid !== 1'b0 || msg_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000", {trig_valid, runcmd_valid, msg_valid}); end
        checks++; if (trig_time !== 15'd0 || runcmd !== 2'd0) begin errors++; $display("FAIL reset_trig_run got %h/%0d exp 0/0", trig_time, runcmd); end
        checks++; if (msg_data !== 32'd0) begin errors++; $display("FAIL reset_msg_data got %h exp 0", msg_data); end
        checks++; if (perr !== 2'd0 || proto !== 2'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", perr, proto); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align got %0b exp 0", align_err); end
    endtask

    task automatic test_trigger();
        send_word(mk(1, 15'h1234, 8'h00, C_IDLE, 2'd0), 8);
        send_word(mk(0, 15'h7FFF, 8'h00, C_IDLE, 2'd2), 8);
    endtask

    task automatic test_parity();
        send_word(mk(1, 15'h1234, 8'h00, C_IDLE, 2'd0) ^ 32'd1, 8);
        send_word(mk(1, 15'h0042, 8'h00, C_IDLE, 2'd1) ^ 32'd1, 8);
    endtask

    task automatic test_message();
        send_word(mk(0, 15'h0, 8'hAA, C_START, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'hBB, C_CONT, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'hCC, C_CONT, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'hDD, C_END, 2'd0), 8);
        checks++; if (msg_data !== 32'hDDCCBBAA) begin errors++; $display("FAIL message_data got %h exp ddccbbaa", msg_data); end
    endtask

    task automatic test_proto();
        send_word(mk(0, 15'h0, 8'h11, C_START, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h22, C_END, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h33, C_CONT, 2'd0), 8);
        checks++; if (proto !== 2'd2) begin errors++; $display("FAIL proto_after_cont got %0d exp 2", proto); end
    endtask

    task automatic test_back_to_back();
        send_word(mk(0, 15'h0, 8'h01, C_START, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h02, C_CONT, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h03, C_CONT, 2'd0), 8);
        send_word(mk(1, 15'h5A5A, 8'h04, C_END, 2'd3), 8);
        send_word(mk(1, 15'h0001, 8'h09, C_START, 2'd1), 8);
        send_word(mk(0, 15'h0, 8'h0A, C_START, 2'd0), 8);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++)
            send_word(mk(i[0], 15'(i), 8'hE0, C_END, 2'd2) ^ 32'h100, 8);
        checks++; if (perr !== 2'd3) begin errors++; $display("FAIL parity_saturate got %0d exp 3", perr); end
    endtask

    task automatic test_align();
        do_reset();
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 7);
        send_word(mk(1, 15'h0077, 8'h00, C_IDLE, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 8);
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_sticky got %0b exp 1", align_err); end
        do_reset();
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL align_cleared got %0b exp 0", align_err); end
    endtask

    task automatic test_mid_reset();
        send_word(mk(0, 15'h0, 8'h10, C_START, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h20, C_CONT, 2'd0), 8);
        send_word(mk(1, 15'h0333, 8'h00, C_IDLE, 2'd1), 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (trig_valid !== 1'b0 || runcmd_valid !== 1'b0) begin errors++; $display("FAIL inflight_dropped got %b exp 00", {trig_valid, runcmd_valid}); end
        end
        send_word(mk(0, 15'h0, 8'h30, C_END, 2'd0), 8);
        send_word(mk(0, 15'h0, 8'h00, C_IDLE, 2'd0), 8);
        checks++; if (msg_data !== 32'd0) begin errors++; $display("FAIL mid_reset_msg got %h exp 0", msg_data); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_parity();
        test_message();
        test_proto();
        test_back_to_back();
        test_saturation();
        test_align();
        test_mid_reset();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d entries exp 0", q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
